// File: rtl/varredura_display_pkg.sv
// Shared definitions for the display scan controller.
// Contents: FSM state encoding, number of scanned digits and the
// leading-zero blanking helper used by the top level.
package varredura_display_pkg;

    typedef enum logic [0:0] {
        PARADO   = 1'b0,
        VARRENDO = 1'b1
    } estado_t;

    localparam int NUM_DIGITOS = 4;

    // A digit k>=1 is a leading zero when it and every higher digit are 0.
    // Digit 0 is never blanked so an all-zero value still shows "0".
    function automatic logic digito_apagado(input logic [15:0] snap, input logic [1:0] sel);
        logic res;
        case (sel)
            2'd0:    res = 1'b0;
            2'd1:    res = (snap[15:4]  == 12'h000);
            2'd2:    res = (snap[15:8]  == 8'h00);
            2'd3:    res = (snap[15:12] == 4'h0);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/varredura_display_divisor_tick.sv
// Prescaler for the scan controller: produces a one-cycle tick every
// PRESCALE clocks while running.
// Ports: clock, reset (sync, active-high), limpar (hold counter at 0,
//        suppress tick), tick (combinational, high on the last count).
module divisor_tick #(
    parameter int PRESCALE = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic limpar,
    output logic tick
);

    localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [W-1:0] ULTIMO = W'(PRESCALE - 1);
    localparam logic [W-1:0] ZERO   = W'(0);
    localparam logic [W-1:0] UM     = W'(1);

    logic [W-1:0] contador_r;

    // Prescale counter: 0..PRESCALE-1, cleared while limpar is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador_r <= ZERO;
        end else if (limpar || (contador_r == ULTIMO)) begin
            contador_r <= ZERO;
        end else begin
            contador_r <= contador_r + UM;
        end
    end

    assign tick = !limpar && (contador_r == ULTIMO);

endmodule

// File: rtl/varredura_display.sv
// Display scan controller: time-multiplexes four 4-bit digits onto one
// shared digit bus, snapshotting the inputs once per frame.
// Ports: clock, reset (sync, active-high), Habilitar (run/stop),
//        Dados[15:0] (digit3..digit0), Selecao[1:0] (active digit index),
//        Digito[3:0] (selected snapshot digit), Apagar (blank current
//        digit), Fim_Quadro (one-cycle end-of-frame pulse).
module varredura_display
    import varredura_display_pkg::*;
#(
    parameter int PRESCALE       = 50000,
    parameter bit SUPRIMIR_ZEROS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Habilitar,
    input  logic [15:0] Dados,
    output logic [1:0]  Selecao,
    output logic [3:0]  Digito,
    output logic        Apagar,
    output logic        Fim_Quadro
);

    localparam logic [1:0] ULTIMO_DIGITO = 2'(NUM_DIGITOS - 1);

    estado_t     state_r, state_next_s;
    logic [1:0]  selecao_r, selecao_next_s;
    logic [15:0] snapshot_r, snapshot_next_s;
    logic        fim_quadro_r, fim_quadro_next_s;
    logic        limpar_s;
    logic        tick_s;

    // The prescaler only runs while scanning continues; a falling Habilitar
    // clears it on the same edge that leaves VARRENDO.
    assign limpar_s = (state_r != VARRENDO) || !Habilitar;

    divisor_tick #(
        .PRESCALE(PRESCALE)
    ) u_divisor (
        .clock (clock),
        .reset (reset),
        .limpar(limpar_s),
        .tick  (tick_s)
    );

    // State, digit index, frame snapshot and frame pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= PARADO;
            selecao_r    <= 2'b00;
            snapshot_r   <= 16'h0000;
            fim_quadro_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            selecao_r    <= selecao_next_s;
            snapshot_r   <= snapshot_next_s;
            fim_quadro_r <= fim_quadro_next_s;
        end
    end

    // Next-state logic: start/stop, digit stepping and frame wrap.
    always_comb begin
        state_next_s      = state_r;
        selecao_next_s    = selecao_r;
        snapshot_next_s   = snapshot_r;
        fim_quadro_next_s = 1'b0;
        case (state_r)
            PARADO: begin
                if (Habilitar) begin
                    state_next_s    = VARRENDO;
                    selecao_next_s  = 2'b00;
                    snapshot_next_s = Dados;
                end else begin
                    selecao_next_s  = 2'b00;
                end
            end
            VARRENDO: begin
                // Stopping wins over a coincident tick: no step, no pulse.
                if (!Habilitar) begin
                    state_next_s   = PARADO;
                    selecao_next_s = 2'b00;
                end else if (tick_s) begin
                    selecao_next_s = selecao_r + 2'b01;
                    if (selecao_r == ULTIMO_DIGITO) begin
                        snapshot_next_s   = Dados;
                        fim_quadro_next_s = 1'b1;
                    end else begin
                        snapshot_next_s   = snapshot_r;
                    end
                end else begin
                    selecao_next_s = selecao_r;
                end
            end
            default: begin
                state_next_s   = PARADO;
                selecao_next_s = 2'b00;
            end
        endcase
    end

    // Outputs: selected digit and blanking, decoded from registers.
    always_comb begin
        Digito = 4'h0;
        Apagar = 1'b1;
        case (selecao_r)
            2'd0:    Digito = snapshot_r[3:0];
            2'd1:    Digito = snapshot_r[7:4];
            2'd2:    Digito = snapshot_r[11:8];
            2'd3:    Digito = snapshot_r[15:12];
            default: Digito = 4'h0;
        endcase
        if (state_r != VARRENDO) begin
            Apagar = 1'b1;
        end else if (SUPRIMIR_ZEROS) begin
            Apagar = digito_apagado(snapshot_r, selecao_r);
        end else begin
            Apagar = 1'b0;
        end
    end

    assign Selecao    = selecao_r;
    assign Fim_Quadro = fim_quadro_r;

endmodule
